// File: rtl/dvs_event_queue_reader.sv
// DVS event queue reader: pulls events from a shared-bus FIFO and forwards
// them one at a time to the RAVENS consumer over a valid/ready handshake.
module dvs_event_queue_reader #(
    parameter int EVENT_BITS = 40,
    parameter int COUNT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic                  fifo_grant,
    input  logic [EVENT_BITS-1:0] fifo_read_event,
    output logic                  fifo_req,
    output logic                  fifo_rd_en,
    output logic [EVENT_BITS-1:0] out_event,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COUNT_BITS-1:0] events_forwarded
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        CAPTURE,
        SEND
    } state_t;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (fifo_grant && !fifo_empty) begin
                    state_nxt = CAPTURE;
                end else if (fifo_empty) begin
                    state_nxt = IDLE;
                end
            end
            CAPTURE: begin
                state_nxt = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    state_nxt = fifo_empty ? IDLE : REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bus stays requested through CAPTURE so read data lands while we own it
    always_comb begin
        fifo_req   = (state == REQ) || (state == CAPTURE);
        fifo_rd_en = (state == REQ) && fifo_grant && !fifo_empty;
        out_valid  = (state == SEND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_event <= '0;
        end else if (state == CAPTURE) begin
            out_event <= fifo_read_event;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            events_forwarded <= '0;
        end else if (out_valid && out_ready && (events_forwarded != '1)) begin
            events_forwarded <= events_forwarded + COUNT_BITS'(1);
        end
    end

endmodule

// File: doc/dvs_event_queue_reader.md
DVS_EVENT_QUEUE_READER -- requirements
Module: dvs_event_queue_reader

Interface
REQ-001 Parameter EVENT_BITS, default 40, SHALL be the width of one queued event word.
REQ-002 Parameter COUNT_BITS, default 16, SHALL be the width of the forwarded-event counter.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-005 Port fifo_empty, input, 1, SHALL be high when the event FIFO holds no entries.
REQ-006 Port fifo_grant, input, 1, SHALL be the read-master grant from the FIFO bus arbiter.
REQ-007 Port fifo_read_event, input, EVENT_BITS, SHALL be the FIFO read data, valid one cycle after fifo_rd_en.
REQ-008 Port fifo_req, output, 1, SHALL be the read-master bus request to the arbiter.
REQ-009 Port fifo_rd_en, output, 1, SHALL be the one-cycle FIFO pop strobe.
REQ-010 Port out_event, output, EVENT_BITS, SHALL be the event presented to the RAVENS consumer.
REQ-011 Port out_valid, output, 1, SHALL flag out_event valid.
REQ-012 Port out_ready, input, 1, SHALL indicate the consumer accepts out_event this cycle.
REQ-013 Port events_forwarded, output, COUNT_BITS, SHALL count completed out_valid&&out_ready transfers.

Function
REQ-014 States SHALL be IDLE, REQ, CAPTURE, SEND.
REQ-015 IDLE: fifo_req=0, fifo_rd_en=0, out_valid=0; go REQ when fifo_empty=0.
REQ-016 REQ: fifo_req=1; if fifo_grant=1 and fifo_empty=0, assert fifo_rd_en for that cycle and go CAPTURE; if fifo_empty=1, go IDLE; otherwise stay.
REQ-017 CAPTURE: fifo_req=1, fifo_rd_en=0; register fifo_read_event into out_event; go SEND.
REQ-018 SEND: fifo_req=0, out_valid=1, out_event stable; on out_ready=1 go REQ if fifo_empty=0, else IDLE.
REQ-019 fifo_rd_en SHALL never be asserted unless fifo_req=1, fifo_grant=1 and fifo_empty=0 in the same cycle.
REQ-020 fifo_rd_en SHALL be asserted at most once per forwarded event; no pop while an event is held in SEND.
REQ-021 fifo_req SHALL remain high through CAPTURE so the bus is held during the read-data cycle.
REQ-022 Minimum latency: fifo_rd_en in cycle t, out_valid high in cycle t+2; sustained throughput one event per 3 cycles with out_ready tied high.
REQ-023 out_event and out_valid SHALL not change while out_valid=1 and out_ready=0.
REQ-024 events_forwarded SHALL increment by 1 per handshake and saturate at 2^COUNT_BITS-1.
REQ-025 Grant lost in REQ (fifo_grant=0) SHALL cause waiting with fifo_req held; no timeout.
REQ-026 out_ready high outside SEND SHALL have no effect.

Reset
REQ-027 While rst_n=0: state=IDLE, fifo_req=0, fifo_rd_en=0, out_valid=0, out_event=0, events_forwarded=0, independent of clk.
REQ-028 Reset asserted in CAPTURE or SEND SHALL discard the held event; no pop after reset release until a new REQ grant.
REQ-029 First fifo_req after reset release SHALL occur no earlier than the first clock edge with rst_n=1 and fifo_empty=0.

Verification
REQ-030 Reset: rst_n=0 mid-SEND with out_event=40'hABCDE12345 -> out_valid=0, out_event=0, events_forwarded=0 immediately.
REQ-031 Single event: fifo_empty=0 one entry 40'h0000_1234_56, grant=1, out_ready=1 -> rd_en one cycle, out_valid one cycle later+1, out_event=40'h0000123456, count=1, return IDLE.
REQ-032 Backpressure: out_ready=0 for 10 cycles in SEND -> out_event/out_valid stable, fifo_rd_en=0 throughout, count unchanged until ready.
REQ-033 Denied grant: fifo_grant=0 for 5 cycles in REQ -> fifo_req=1, fifo_rd_en=0 for all 5; pop on first granted cycle.
REQ-034 Burst: 4 entries, grant=1, out_ready=1 -> 4 pops at 3-cycle spacing, events in FIFO order, count=4, IDLE when empty.
REQ-035 Saturation: COUNT_BITS=2, 5 transfers -> events_forwarded=3 after 3rd and stays 3.
